// File: rtl/icache_dm_pkg.sv
// ============================================================================
// Module      : icache_dm_pkg
// Description : Shared types and address-split helpers for the direct-mapped I-cache.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package icache_dm_pkg;

    localparam int REG_WIDTH = 32;
    typedef logic [REG_WIDTH-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        RESPOND  = 2'd3
    } icache_state_e;

    function automatic int off_width(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int line_words, input int sets);
        return addr_w - off_width(line_words) - idx_width(sets);
    endfunction

    localparam int DEF_OFF_W = off_width(8);
    localparam int DEF_IDX_W = idx_width(64);
    localparam int DEF_TAG_W = tag_width(REG_WIDTH, 8, 64);

    // Field view of a PC for the default geometry (8-word lines, 64 sets).
    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_IDX_W-1:0] index;
        logic [DEF_OFF_W-1:0] offset;
    } icache_addr_t;

    function automatic icache_addr_t split_addr(input pc_t pc);
        return icache_addr_t'(pc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_select.sv
// ============================================================================
// Module      : icache_line_select
// Description : Picks FETCH_WIDTH consecutive words from one line, masking lanes past the line end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module icache_line_select
    import icache_dm_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int LINE_WORDS  = 8
) (
    input  logic [LINE_WORDS*32-1:0]       line_i,
    input  logic [$clog2(LINE_WORDS)-1:0]  w0_i,
    output logic [FETCH_WIDTH*32-1:0]      inst_o,
    output logic [FETCH_WIDTH-1:0]         mask_o
);

    localparam int WO_W   = $clog2(LINE_WORDS);
    localparam int LANE_W = WO_W + 1;

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
            // One extra bit so w0 + i past the last word compares as out of line.
            logic [LANE_W-1:0] w_lane;
            logic [WO_W-1:0]   w_word;
            assign w_lane    = {1'b0, w0_i} + LANE_W'(i);
            assign w_word    = w_lane[WO_W-1:0];
            assign mask_o[i] = (w_lane < LANE_W'(LINE_WORDS));
            assign inst_o[i*32 +: 32] = mask_o[i] ? line_i[w_word*32 +: 32] : 32'd0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped multi-word-line instruction cache with word-serial refill and flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int FETCH_WIDTH = 4,
    parameter int LINE_WORDS  = 8,
    parameter int SETS        = 64,
    parameter int ADDR_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [ADDR_W-1:0]         req_pc,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [ADDR_W-1:0]         resp_pc,
    output logic [FETCH_WIDTH*32-1:0] resp_inst,
    output logic [FETCH_WIDTH-1:0]    resp_mask,
    input  logic                      flush,
    output logic                      mem_req_valid,
    output logic [ADDR_W-1:0]         mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, SETS);
    localparam int WO_W  = OFF_W - 2;

    icache_state_e          state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [WO_W-1:0]        beat_q, beat_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   hit_q, hit_d;
    logic [SETS-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [SETS];
    logic [LINE_WORDS*32-1:0] data_q [SETS];

    logic [IDX_W-1:0]       w_req_idx, w_pc_idx;
    logic [TAG_W-1:0]       w_req_tag, w_pc_tag;
    logic [WO_W-1:0]        w_pc_w0;
    logic                   w_accept, w_lookup_hit, w_beat, w_last_beat;
    logic [FETCH_WIDTH*32-1:0] w_sel_inst;
    logic [FETCH_WIDTH-1:0] w_sel_mask;
    logic                   w_unused;

    assign w_req_idx    = req_pc[OFF_W +: IDX_W];
    assign w_req_tag    = req_pc[ADDR_W-1 -: TAG_W];
    assign w_pc_idx     = pc_q[OFF_W +: IDX_W];
    assign w_pc_tag     = pc_q[ADDR_W-1 -: TAG_W];
    assign w_pc_w0      = pc_q[2 +: WO_W];
    assign w_unused     = ^req_pc[1:0];

    assign req_ready    = (state_q == IDLE) && !flush && !rst;
    assign w_accept     = req_valid && req_ready;
    assign w_lookup_hit = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
    assign w_beat       = (state_q == REFILL) && mem_resp_valid;
    assign w_last_beat  = w_beat && (beat_q == WO_W'(LINE_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        hit_d        = 1'b0;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (w_accept) begin
                    pc_d = req_pc;
                    if (w_lookup_hit) hit_d   = 1'b1;
                    else              state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (w_beat) beat_d = beat_q + 1'b1;
                if (w_last_beat) begin
                    // Explicitly clear too: the old tag of this set no longer matches its data.
                    valid_d[w_pc_idx] = !(flush_pend_q || flush);
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                if (flush_pend_q || flush) valid_d = '0;
                flush_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            hit_q        <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            hit_q        <= hit_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data storage is never reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            data_q[w_pc_idx][beat_q*32 +: 32] <= mem_resp_data;
        end
        if (w_last_beat) begin
            tag_q[w_pc_idx] <= w_pc_tag;
        end
    end

    // pc_q cannot change while a response is presented, so hit and refill share one selector.
    icache_line_select #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .LINE_WORDS  (LINE_WORDS)
    ) u_line_select (
        .line_i (data_q[w_pc_idx]),
        .w0_i   (w_pc_w0),
        .inst_o (w_sel_inst),
        .mask_o (w_sel_mask)
    );

    assign resp_valid    = hit_q || (state_q == RESPOND);
    assign resp_pc       = pc_q;
    assign resp_inst     = resp_valid ? w_sel_inst : '0;
    assign resp_mask     = resp_valid ? w_sel_mask : '0;
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

endmodule

`default_nettype wire
